// File: rtl/data_sram_req_ctrl.sv
// EX-stage data-memory request controller: issues load/store requests on the class-SRAM port,
// holds them until the address handshake, and drops responses of flushed transactions.
module data_sram_req_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        ex_mem_req_i,
    input  logic        ex_mem_wr_i,
    input  logic [1:0]  ex_mem_size_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_wdata_i,
    input  logic        ex_excep_en_i,
    input  logic        mem_allowin_i,
    input  logic        excep_flush_i,
    output logic        ex_req_ready_o,
    output logic        data_sram_req_o,
    output logic        data_sram_wr_o,
    output logic [1:0]  data_sram_size_o,
    output logic [3:0]  data_sram_wstrb_o,
    output logic [31:0] data_sram_addr_o,
    output logic [31:0] data_sram_wdata_o,
    input  logic        data_sram_addr_ok_i,
    input  logic        data_sram_data_ok_i,
    input  logic [31:0] data_sram_rdata_i,
    output logic        mem_data_ok_o,
    output logic [31:0] mem_rdata_o
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] cancel_cnt_q, cancel_cnt_d;
    logic             hold_cancel_q, hold_cancel_d;
    logic             lat_wr_q, lat_wr_d;
    logic [1:0]       lat_size_q, lat_size_d;
    logic [3:0]       lat_wstrb_q, lat_wstrb_d;
    logic [31:0]      lat_addr_q, lat_addr_d;
    logic [31:0]      lat_wdata_q, lat_wdata_d;

    logic        ex_mem_act, need_req, can_issue, hold_cxl;
    logic        req, accept, ready_ok, cxl_inc, cxl_dec;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb, ex_wstrb;
    logic [31:0] req_addr, req_wdata, ex_wdata;

    assign ex_mem_act = ex_valid_i & ex_mem_req_i & ~ex_excep_en_i;
    assign need_req   = ex_mem_act & ~excep_flush_i & mem_allowin_i;
    assign can_issue  = (out_cnt_q < CNT_W'(MAX_OUTSTANDING)) | data_sram_data_ok_i;
    assign hold_cxl   = hold_cancel_q | excep_flush_i;

    always_comb begin
        ex_wstrb = 4'b0000;
        ex_wdata = ex_mem_wdata_i;
        case (ex_mem_size_i)
            2'd0: begin
                ex_wdata = {4{ex_mem_wdata_i[7:0]}};
                if (ex_mem_wr_i) ex_wstrb = 4'b0001 << ex_mem_addr_i[1:0];
            end
            2'd1: begin
                ex_wdata = {2{ex_mem_wdata_i[15:0]}};
                if (ex_mem_wr_i) ex_wstrb = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (ex_mem_wr_i) ex_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hold_cancel_d = 1'b0;
        lat_wr_d      = lat_wr_q;
        lat_size_d    = lat_size_q;
        lat_wstrb_d   = lat_wstrb_q;
        lat_addr_d    = lat_addr_q;
        lat_wdata_d   = lat_wdata_q;
        req           = 1'b0;
        req_wr        = 1'b0;
        req_size      = 2'd0;
        req_wstrb     = 4'b0000;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        ready_ok      = 1'b0;
        case (state_q)
            StIdle: begin
                req = need_req & can_issue;
                if (req) begin
                    req_wr    = ex_mem_wr_i;
                    req_size  = ex_mem_size_i;
                    req_wstrb = ex_wstrb;
                    req_addr  = ex_mem_addr_i;
                    req_wdata = ex_wdata;
                end
                if (req & ~data_sram_addr_ok_i) begin
                    state_d     = StHold;
                    lat_wr_d    = ex_mem_wr_i;
                    lat_size_d  = ex_mem_size_i;
                    lat_wstrb_d = ex_wstrb;
                    lat_addr_d  = ex_mem_addr_i;
                    lat_wdata_d = ex_wdata;
                end
                ready_ok = req & data_sram_addr_ok_i;
            end
            StHold: begin
                // Once on the bus a request must stay put, even across a flush.
                req       = 1'b1;
                req_wr    = lat_wr_q;
                req_size  = lat_size_q;
                req_wstrb = lat_wstrb_q;
                req_addr  = lat_addr_q;
                req_wdata = lat_wdata_q;
                if (data_sram_addr_ok_i) begin
                    state_d = StIdle;
                end else begin
                    hold_cancel_d = hold_cxl;
                end
                ready_ok = data_sram_addr_ok_i & ~hold_cxl;
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = req & data_sram_addr_ok_i;

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({accept, data_sram_data_ok_i})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = (out_cnt_q != '0) ? out_cnt_q - 1'b1 : '0;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    assign cxl_inc = (state_q == StHold) & accept & hold_cancel_q;
    assign cxl_dec = data_sram_data_ok_i & (cancel_cnt_q != '0);

    always_comb begin
        cancel_cnt_d = cancel_cnt_q;
        if (excep_flush_i) begin
            // Everything still in flight after this cycle belongs to killed instructions.
            cancel_cnt_d = out_cnt_d;
        end else if (cxl_inc & ~cxl_dec) begin
            cancel_cnt_d = cancel_cnt_q + 1'b1;
        end else if (~cxl_inc & cxl_dec) begin
            cancel_cnt_d = cancel_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            out_cnt_q     <= '0;
            cancel_cnt_q  <= '0;
            hold_cancel_q <= 1'b0;
            lat_wr_q      <= 1'b0;
            lat_size_q    <= 2'd0;
            lat_wstrb_q   <= 4'b0000;
            lat_addr_q    <= 32'd0;
            lat_wdata_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            out_cnt_q     <= out_cnt_d;
            cancel_cnt_q  <= cancel_cnt_d;
            hold_cancel_q <= hold_cancel_d;
            lat_wr_q      <= lat_wr_d;
            lat_size_q    <= lat_size_d;
            lat_wstrb_q   <= lat_wstrb_d;
            lat_addr_q    <= lat_addr_d;
            lat_wdata_q   <= lat_wdata_d;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign data_sram_req_o   = rst_n & req;
    assign data_sram_wr_o    = rst_n & req_wr;
    assign data_sram_size_o  = {2{rst_n}} & req_size;
    assign data_sram_wstrb_o = {4{rst_n}} & req_wstrb;
    assign data_sram_addr_o  = {32{rst_n}} & req_addr;
    assign data_sram_wdata_o = {32{rst_n}} & req_wdata;
    assign ex_req_ready_o    = rst_n & (~ex_mem_act | ready_ok);
    assign mem_data_ok_o     = rst_n & data_sram_data_ok_i & (cancel_cnt_q == '0);
    assign mem_rdata_o       = {32{rst_n}} & data_sram_rdata_i;

`ifndef SYNTHESIS
    data_ok_without_txn: assert property (@(posedge clk) disable iff (!rst_n)
        data_sram_data_ok_i |-> (out_cnt_q != '0));
    outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        out_cnt_q <= CNT_W'(MAX_OUTSTANDING));
`endif

endmodule

// File: tb/tb_data_sram_req_ctrl.sv
// Directed bench for data_sram_req_ctrl; a transaction-level model (queue of in-flight
// transactions tagged live/killed plus one pending bus request) is checked every cycle.
module tb_data_sram_req_ctrl;

    localparam int unsigned MaxOut = 2;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_mem_req, ex_mem_wr, ex_excep_en, mem_allowin, excep_flush;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_mem_addr, ex_mem_wdata;
    logic        ex_req_ready;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    data_sram_req_ctrl #(
        .MAX_OUTSTANDING(MaxOut),
        .CNT_W          (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid_i         (ex_valid),
        .ex_mem_req_i       (ex_mem_req),
        .ex_mem_wr_i        (ex_mem_wr),
        .ex_mem_size_i      (ex_mem_size),
        .ex_mem_addr_i      (ex_mem_addr),
        .ex_mem_wdata_i     (ex_mem_wdata),
        .ex_excep_en_i      (ex_excep_en),
        .mem_allowin_i      (mem_allowin),
        .excep_flush_i      (excep_flush),
        .ex_req_ready_o     (ex_req_ready),
        .data_sram_req_o    (sram_req),
        .data_sram_wr_o     (sram_wr),
        .data_sram_size_o   (sram_size),
        .data_sram_wstrb_o  (sram_wstrb),
        .data_sram_addr_o   (sram_addr),
        .data_sram_wdata_o  (sram_wdata),
        .data_sram_addr_ok_i(addr_ok),
        .data_sram_data_ok_i(data_ok),
        .data_sram_rdata_i  (rdata),
        .mem_data_ok_o      (mem_data_ok),
        .mem_rdata_o        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_wstrb(input logic wr, input logic [1:0] size,
                                           input logic [1:0] a);
        if (!wr) return 4'b0000;
        case (size)
            2'd0:    return 4'(4'b0001 << a);
            2'd1:    return (a >= 2'd2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Model: one entry per accepted transaction, 1 = its instruction was killed.
    bit          txn_dead[$];
    bit          pend_v = 1'b0;
    bit          pend_kill = 1'b0;
    logic        pend_wr;
    logic [1:0]  pend_size;
    logic [3:0]  pend_wstrb;
    logic [31:0] pend_addr, pend_wdata;

    always @(negedge clk) begin
        logic        act, issue, acc, kill_now, e_req, e_rdy, e_dok, e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        if (!rst_n) begin
            chk("rst_req", {31'd0, sram_req}, 32'd0);
            chk("rst_wr", {31'd0, sram_wr}, 32'd0);
            chk("rst_size", {30'd0, sram_size}, 32'd0);
            chk("rst_wstrb", {28'd0, sram_wstrb}, 32'd0);
            chk("rst_addr", sram_addr, 32'd0);
            chk("rst_wdata", sram_wdata, 32'd0);
            chk("rst_ready", {31'd0, ex_req_ready}, 32'd0);
            chk("rst_mem_dok", {31'd0, mem_data_ok}, 32'd0);
            chk("rst_mem_rdata", mem_rdata, 32'd0);
            txn_dead.delete();
            pend_v = 1'b0;
            pend_kill = 1'b0;
        end else begin
            act = ex_valid && ex_mem_req && !ex_excep_en;
            issue = 1'b0;
            if (pend_v) begin
                e_req = 1'b1;
                e_wr = pend_wr;
                e_size = pend_size;
                e_wstrb = pend_wstrb;
                e_addr = pend_addr;
                e_wdata = pend_wdata;
                acc = addr_ok;
                kill_now = pend_kill || excep_flush;
                e_rdy = !act || (addr_ok && !kill_now);
            end else begin
                issue = act && mem_allowin && !excep_flush &&
                        (txn_dead.size() < MaxOut || data_ok);
                e_req = issue;
                e_wr = ex_mem_wr;
                e_size = ex_mem_size;
                e_wstrb = m_wstrb(ex_mem_wr, ex_mem_size, ex_mem_addr[1:0]);
                e_addr = ex_mem_addr;
                e_wdata = m_wdata(ex_mem_size, ex_mem_wdata);
                acc = issue && addr_ok;
                kill_now = 1'b0;
                e_rdy = !act || acc;
            end
            e_dok = data_ok && !(txn_dead.size() > 0 && txn_dead[0]);
            chk("m_req", {31'd0, sram_req}, {31'd0, e_req});
            chk("m_ready", {31'd0, ex_req_ready}, {31'd0, e_rdy});
            chk("m_mem_dok", {31'd0, mem_data_ok}, {31'd0, e_dok});
            chk("m_mem_rdata", mem_rdata, rdata);
            if (e_req) begin
                chk("m_wr", {31'd0, sram_wr}, {31'd0, e_wr});
                chk("m_size", {30'd0, sram_size}, {30'd0, e_size});
                chk("m_wstrb", {28'd0, sram_wstrb}, {28'd0, e_wstrb});
                chk("m_addr", sram_addr, e_addr);
                if (e_wr) chk("m_wdata", sram_wdata, e_wdata);
            end
            if (data_ok && txn_dead.size() > 0) void'(txn_dead.pop_front());
            if (acc) txn_dead.push_back(kill_now);
            if (excep_flush) foreach (txn_dead[i]) txn_dead[i] = 1'b1;
            if (pend_v) begin
                if (addr_ok) pend_v = 1'b0;
                else pend_kill = kill_now;
            end else if (issue && !addr_ok) begin
                pend_v = 1'b1;
                pend_kill = 1'b0;
                pend_wr = e_wr;
                pend_size = e_size;
                pend_wstrb = e_wstrb;
                pend_addr = e_addr;
                pend_wdata = e_wdata;
            end
        end
    end

    task automatic idle_in();
        ex_valid = 1'b0; ex_mem_req = 1'b0; ex_mem_wr = 1'b0; ex_mem_size = 2'd0;
        ex_mem_addr = 32'd0; ex_mem_wdata = 32'd0; ex_excep_en = 1'b0; mem_allowin = 1'b1;
        excep_flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
    endtask

    task automatic ld(input logic [31:0] a);
        ex_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_wr = 1'b0; ex_mem_size = 2'd2; ex_mem_addr = a;
    endtask

    task automatic peek();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_mem_req = 1'b1; data_ok = 1'b1; rdata = 32'h0000_0123;
        peek();
        chk("rst_lit_ready", {31'd0, ex_req_ready}, 32'd0);
        chk("rst_lit_rdata", mem_rdata, 32'd0);
        nxt(); idle_in(); nxt(); rst_n = 1'b1; nxt();

        // Zero-wait load.
        ld(32'h1000_0004); addr_ok = 1'b1;
        peek();
        chk("t1_req", {31'd0, sram_req}, 32'd1);
        chk("t1_ready", {31'd0, ex_req_ready}, 32'd1);
        chk("t1_addr", sram_addr, 32'h1000_0004);
        nxt(); idle_in(); data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        peek();
        chk("t1_req_off", {31'd0, sram_req}, 32'd0);
        chk("t1_dok", {31'd0, mem_data_ok}, 32'd1);
        chk("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
        nxt(); idle_in();

        // Byte store held three cycles while EX inputs change.
        ex_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_wr = 1'b1; ex_mem_size = 2'd0;
        ex_mem_addr = 32'h2000_0003; ex_mem_wdata = 32'h0000_00A5;
        peek();
        chk("t2_req0", {31'd0, sram_req}, 32'd1);
        chk("t2_wstrb0", {28'd0, sram_wstrb}, 32'h8);
        chk("t2_wdata0", sram_wdata, 32'hA5A5_A5A5);
        chk("t2_ready0", {31'd0, ex_req_ready}, 32'd0);
        nxt();
        ex_mem_addr = 32'h3000_0000; ex_mem_wdata = 32'h1234_5678; ex_mem_size = 2'd2;
        for (int i = 0; i < 2; i++) begin
            peek();
            chk("t2_req_hold", {31'd0, sram_req}, 32'd1);
            chk("t2_addr_hold", sram_addr, 32'h2000_0003);
            chk("t2_wstrb_hold", {28'd0, sram_wstrb}, 32'h8);
            chk("t2_ready_hold", {31'd0, ex_req_ready}, 32'd0);
            nxt();
        end
        addr_ok = 1'b1;
        peek();
        chk("t2_req_acc", {31'd0, sram_req}, 32'd1);
        chk("t2_wdata_acc", sram_wdata, 32'hA5A5_A5A5);
        chk("t2_ready_acc", {31'd0, ex_req_ready}, 32'd1);
        nxt(); idle_in(); data_ok = 1'b1;
        peek();
        chk("t2_dok", {31'd0, mem_data_ok}, 32'd1);
        nxt(); idle_in();

        // Flush after an accepted load kills its response only.
        ld(32'h0000_0040); addr_ok = 1'b1;
        peek();
        chk("t3_ready", {31'd0, ex_req_ready}, 32'd1);
        nxt(); idle_in(); excep_flush = 1'b1;
        peek(); nxt(); idle_in();
        chk("t3_model_cancel", {31'd0, (txn_dead.size() == 1 && txn_dead[0])}, 32'd1);
        peek(); nxt();
        data_ok = 1'b1; rdata = 32'h0000_1111;
        peek();
        chk("t3_dok_filtered", {31'd0, mem_data_ok}, 32'd0);
        nxt(); idle_in(); ld(32'h0000_0044); addr_ok = 1'b1;
        peek();
        chk("t3_req2", {31'd0, sram_req}, 32'd1);
        nxt(); idle_in(); data_ok = 1'b1; rdata = 32'h0000_2222;
        peek();
        chk("t3_dok2", {31'd0, mem_data_ok}, 32'd1);
        chk("t3_rdata2", mem_rdata, 32'h0000_2222);
        nxt(); idle_in();

        // Flush while holding.
        ld(32'h0000_0080);
        peek();
        chk("t4_ready0", {31'd0, ex_req_ready}, 32'd0);
        nxt(); excep_flush = 1'b1;
        peek();
        chk("t4_req_flush", {31'd0, sram_req}, 32'd1);
        nxt(); excep_flush = 1'b0;
        peek();
        chk("t4_req_after", {31'd0, sram_req}, 32'd1);
        chk("t4_addr_after", sram_addr, 32'h0000_0080);
        nxt(); addr_ok = 1'b1;
        peek();
        chk("t4_req_acc", {31'd0, sram_req}, 32'd1);
        chk("t4_ready_acc", {31'd0, ex_req_ready}, 32'd0);
        nxt(); idle_in(); data_ok = 1'b1; rdata = 32'h0000_3333;
        peek();
        chk("t4_dok_filtered", {31'd0, mem_data_ok}, 32'd0);
        nxt(); idle_in();

        // Outstanding limit, third load waits for a response.
        ld(32'h0000_0100); addr_ok = 1'b1;
        peek(); nxt();
        ld(32'h0000_0104);
        peek(); nxt();
        ld(32'h0000_0108);
        for (int i = 0; i < 2; i++) begin
            peek();
            chk("t5_req_blocked", {31'd0, sram_req}, 32'd0);
            chk("t5_ready_blocked", {31'd0, ex_req_ready}, 32'd0);
            nxt();
        end
        data_ok = 1'b1; rdata = 32'h0000_AAAA;
        peek();
        chk("t5_req_with_dok", {31'd0, sram_req}, 32'd1);
        chk("t5_addr_with_dok", sram_addr, 32'h0000_0108);
        chk("t5_dok", {31'd0, mem_data_ok}, 32'd1);
        nxt(); idle_in(); data_ok = 1'b1;
        peek(); nxt(); peek(); nxt(); idle_in();
        chk("t5_model_empty", txn_dead.size(), 32'd0);

        // Halfword store with and without exception.
        ex_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_wr = 1'b1; ex_mem_size = 2'd1;
        ex_mem_addr = 32'h0000_0202; ex_mem_wdata = 32'h0000_BEEF; ex_excep_en = 1'b1;
        addr_ok = 1'b1;
        peek();
        chk("t6_req_excep", {31'd0, sram_req}, 32'd0);
        chk("t6_ready_excep", {31'd0, ex_req_ready}, 32'd1);
        nxt(); ex_excep_en = 1'b0;
        peek();
        chk("t6_wstrb", {28'd0, sram_wstrb}, 32'hC);
        chk("t6_wdata", sram_wdata, 32'hBEEF_BEEF);
        nxt(); idle_in(); data_ok = 1'b1;
        peek(); nxt(); idle_in();

        // Flush coinciding with data_ok of a live transaction, then flush blocking an issue.
        ld(32'h0000_0500); addr_ok = 1'b1;
        peek(); nxt(); idle_in();
        excep_flush = 1'b1; data_ok = 1'b1; rdata = 32'h0000_5555;
        peek();
        chk("x_dok_on_flush", {31'd0, mem_data_ok}, 32'd1);
        nxt(); idle_in();
        ld(32'h0000_0504); addr_ok = 1'b1; excep_flush = 1'b1;
        peek();
        chk("x_req_flush", {31'd0, sram_req}, 32'd0);
        nxt(); idle_in();
        ld(32'h0000_0508); addr_ok = 1'b1; mem_allowin = 1'b0;
        peek();
        chk("x_req_allowin", {31'd0, sram_req}, 32'd0);
        nxt(); idle_in();
        ex_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_wr = 1'b1; ex_mem_size = 2'd3;
        ex_mem_addr = 32'h0000_0601; ex_mem_wdata = 32'h0102_0304; addr_ok = 1'b1;
        peek();
        chk("x_wstrb_size3", {28'd0, sram_wstrb}, 32'hF);
        nxt(); idle_in(); data_ok = 1'b1;
        peek(); nxt(); idle_in();

        // Reset in the middle of a held request.
        ld(32'h0000_0700);
        peek(); nxt();
        rst_n = 1'b0;
        peek();
        chk("r_req_in_reset", {31'd0, sram_req}, 32'd0);
        nxt(); idle_in(); rst_n = 1'b1; nxt();
        ld(32'h0000_0704); addr_ok = 1'b1;
        peek();
        chk("r_addr_after", sram_addr, 32'h0000_0704);
        nxt(); idle_in(); data_ok = 1'b1;
        peek();
        chk("r_dok_after", {31'd0, mem_data_ok}, 32'd1);
        nxt(); idle_in(); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_req_ctrl.md
Name: data_sram_req_ctrl

Overview:
EX-stage data-memory request controller. It sits directly upstream of the MEM stage and drives the class-SRAM data port: it issues load/store requests, holds each request until the address handshake completes, and tracks outstanding transactions. After an exception flush it filters `data_ok` responses, so MEM only sees `data_sram_data_ok`/`rdata` belonging to live instructions.

Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions (1..3).
- `CNT_W`, default 2: width of the outstanding and cancel counters; must hold `MAX_OUTSTANDING`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ex_valid_i` in 1: EX holds a valid instruction.
- `ex_mem_req_i` in 1: the instruction is a load/store.
- `ex_mem_wr_i` in 1: 1 = store.
- `ex_mem_size_i` in 2: 0 byte, 1 half, 2 word.
- `ex_mem_addr_i` in 32: byte address.
- `ex_mem_wdata_i` in 32: store data, right-aligned.
- `ex_excep_en_i` in 1: EX instruction carries an exception; suppresses its request.
- `mem_allowin_i` in 1: MEM allows a new instruction in.
- `excep_flush_i` in 1: pipeline flush.
- `ex_req_ready_o` out 1: EX memory part done; ANDed into EX ready_go.
- `data_sram_req_o` out 1
- `data_sram_wr_o` out 1
- `data_sram_size_o` out 2
- `data_sram_wstrb_o` out 4
- `data_sram_addr_o` out 32
- `data_sram_wdata_o` out 32
- `data_sram_addr_ok_i` in 1
- `data_sram_data_ok_i` in 1
- `data_sram_rdata_i` in 32
- `mem_data_ok_o` out 1: filtered `data_ok` to MEM.
- `mem_rdata_o` out 32: `data_sram_rdata_i` passed through.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
  - Reset state: FSM = IDLE; outstanding_cnt = 0; cancel_cnt = 0; all latched request registers = 0.
  - All outputs are 0 during reset.
- Issue condition: `need_req = ex_valid_i & ex_mem_req_i & ~ex_excep_en_i & ~excep_flush_i & mem_allowin_i`.
- `can_issue = (outstanding_cnt < MAX_OUTSTANDING) | data_sram_data_ok_i`.
- FSM IDLE:
  - `data_sram_req_o = need_req & can_issue`; request fields are taken combinationally from the `ex_*` inputs.
  - Request asserted with `addr_ok` = 1: stay in IDLE.
  - Request asserted with `addr_ok` = 0: latch wr/size/wstrb/addr/wdata and go to HOLD.
- FSM HOLD:
  - `data_sram_req_o = 1`; all fields driven from the latched copies, bit-stable until `addr_ok`.
  - A request is never withdrawn, including on flush.
  - `addr_ok` returns the FSM to IDLE.
  - `hold_cancel` flag: set if `excep_flush_i` is seen in HOLD or on the entry cycle; cleared on exit.
- `ex_req_ready_o`:
  - 1 when `~(ex_valid_i & ex_mem_req_i & ~ex_excep_en_i)`.
  - Otherwise 1 only in the cycle `data_sram_req_o & data_sram_addr_ok_i` with FSM in IDLE, or in HOLD with `hold_cancel` = 0.
  - Zero-wait accept is therefore possible.
- Outstanding counter:
  - +1 on `req & addr_ok`; −1 on `data_ok`.
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_OUTSTANDING`, never underflows. A `data_ok` with count 0 is a protocol error: flag it in the assertion and leave the count at 0.
- Cancel counter:
  - On `excep_flush_i`: `cancel_cnt` ← outstanding count after this cycle's update, counting a HOLD request accepted this cycle.
  - A HOLD request accepted later with `hold_cancel` = 1 increments `cancel_cnt` on `addr_ok`.
  - Each `data_ok` with `cancel_cnt` > 0 decrements it.
- Response filter: `mem_data_ok_o = data_sram_data_ok_i & (cancel_cnt == 0)`. Combinational, zero latency.
- Write strobe, loads: `wstrb` = 0000.
- Write strobe, stores:
  - size 0: `wstrb = 4'b0001 << addr[1:0]`.
  - size 1: `addr[1]` ? 1100 : 0011.
  - size 2: 1111.
  - size 3: treated as word.
- Write data, stores:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: as is.
- Alignment: not checked here (EX raises ALE and sets `ex_excep_en_i`).
- Simultaneous events:
  - Flush and a new IDLE request in the same cycle: no request issued.
  - Flush and `data_ok` in the same cycle: that `data_ok` is still filtered with the pre-flush `cancel_cnt`, i.e. forwarded if `cancel_cnt` was 0. It belongs to an older instruction already in MEM, which the flush also kills.
  - MEM drops it via `valid`.
- Reset mid-transaction: all state cleared immediately. Bus-side recovery is the SRAM bridge's responsibility; it is reset by the same `rst_n`.

Test Plan:
1. Load word, addr 0x1000_0004, `addr_ok` same cycle, `data_ok` next cycle with rdata 0xDEAD_BEEF.
   - Required: `req` high for 1 cycle; `ex_req_ready_o` = 1 that cycle.
   - Required: next cycle `mem_data_ok_o` = 1 and `mem_rdata_o` = 0xDEAD_BEEF; outstanding returns to 0.
2. Store byte 0xA5 to addr 0x...0003, `addr_ok` delayed 3 cycles, `ex_*` inputs changing meanwhile.
   - Required: `req` held for 4 cycles with wstrb = 1000, wdata = 0xA5A5_A5A5, addr constant.
   - Required: `ex_req_ready_o` = 0 for 3 cycles, then 1.
3. Load accepted, `excep_flush_i` pulsed before `data_ok`.
   - Required: `cancel_cnt` = 1; the later `data_ok` yields `mem_data_ok_o` = 0; `cancel_cnt` returns to 0.
   - Required: a subsequent load's `data_ok` is forwarded.
4. Flush while in HOLD.
   - Required: `req` stays 1 until `addr_ok`; that transaction's `data_ok` is suppressed.
   - Required: `ex_req_ready_o` is not asserted for it.
5. Two back-to-back loads with `data_ok` withheld (`MAX_OUTSTANDING` = 2), third load presented.
   - Required: `req` = 0 for the third load until `data_ok` arrives.
   - Required: `req` rises in the same cycle as that `data_ok`.
6. Halfword store, addr[1] = 1, `ex_excep_en_i` = 1.
   - Required: no `req`; `ex_req_ready_o` = 1.
   - Required: same store with `ex_excep_en_i` = 0 gives wstrb = 1100.
